// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, default widths, index sizing.
package mem_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester scanning from ptr_i upward, wrapping.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  int unsigned k;

  always_comb begin
    k       = 0;
    grant_o = '0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(ptr_i) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found_o && valid_i[k[IDX_W-1:0]]) begin
        found_o               = 1'b1;
        idx_o                 = k[IDX_W-1:0];
        grant_o[k[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port, one transaction in flight.
// Optional ARB_LOCK_EN: owner holding req_lock keeps the port across transactions.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] req_be,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic                          mem_valid,
  input  logic                          mem_ready,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_we,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [DATA_W/8-1:0]           mem_be,
  input  logic                          mem_rvalid,
  input  logic [DATA_W-1:0]             mem_rdata
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);
  localparam int unsigned BE_W  = DATA_W / 8;

  arb_state_e          state_q;
  logic [IDX_W-1:0]    ptr_q, owner_q, ptr_next;
  logic [NUM_REQ-1:0]  resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                mem_valid_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BE_W-1:0]     mem_be_q;

  logic [NUM_REQ-1:0]  pick_valid, pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;
  logic                sel_we;

`ifdef ARB_LOCK_EN
  logic locked_q;
  logic lock_hold;

  // While the owner keeps its lock, only the owner may win the next grant.
  assign lock_hold  = locked_q && req_lock[owner_q];
  assign pick_valid = lock_hold ? (req_valid & (NUM_REQ'(1) << owner_q)) : req_valid;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign pick_valid  = req_valid;
`endif

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i (pick_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // One-hot AND-OR payload mux driven by the picker grant.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_we    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_addr  = sel_addr  | req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
        sel_be    = sel_be    | req_be[i*BE_W +: BE_W];
        sel_we    = sel_we    | req_we[i];
      end
    end
  end

  assign ptr_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // Acceptance is reported in the same cycle memory takes the request.
  always_comb begin
    req_ready = '0;
    if (state_q == ARB_REQ && mem_ready) req_ready[owner_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
`ifdef ARB_LOCK_EN
      locked_q     <= 1'b0;
`endif
    end else begin
      resp_valid_q <= '0;
      case (state_q)
        ARB_IDLE: begin
`ifdef ARB_LOCK_EN
          if (locked_q && !req_lock[owner_q]) locked_q <= 1'b0;
`endif
          if (pick_found) begin
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_be_q    <= sel_be;
            mem_we_q    <= sel_we;
            owner_q     <= pick_idx;
            mem_valid_q <= 1'b1;
            state_q     <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_rvalid) begin
            resp_valid_q[owner_q] <= 1'b1;
            resp_rdata_q          <= mem_rdata;
            state_q               <= ARB_IDLE;
`ifdef ARB_LOCK_EN
            locked_q <= req_lock[owner_q];
            if (!req_lock[owner_q]) ptr_q <= ptr_next;
`else
            ptr_q <= ptr_next;
`endif
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_mem_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready, req_we, req_lock, resp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*DW/8-1:0] req_be;
  logic [DW-1:0]     resp_rdata, mem_wdata, mem_rdata;
  logic              mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [AW-1:0]     mem_addr;
  logic [DW/8-1:0]   mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be), .req_lock(req_lock),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv;
    logic        mr;
    logic        rvl;
    logic [31:0] rdata;
    logic [3:0]  e_rr;
    logic        e_mv;
    logic [31:0] e_addr;
    logic [3:0]  e_resp;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_lock   = '0;
    req_we     = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Full transaction with zero-wait memory; lk is applied to req_lock before completion.
  task automatic do_txn(input string nm, input logic [3:0] rv, input int exp,
                        input logic [31:0] rd, input logic [3:0] lk);
    logic [3:0] got;
    logic [3:0] want;
    bit seen;
    got  = '0;
    seen = 0;
    want = 4'b0001 << exp;
    req_valid = rv;
    mem_ready = 1'b1;
    for (int c = 0; c < 12 && !seen; c++) begin
      tick();
      if (req_ready != '0) begin
        seen = 1;
        got  = req_ready;
      end
    end
    chk({nm, "_grant"}, 64'(got), 64'(want));
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    req_lock   = lk;
    tick();
    mem_ready = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    chk({nm, "_resp"}, 64'(resp_valid), 64'(want));
    chk({nm, "_rdata"}, 64'(resp_rdata), 64'(rd));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]    = 32'h100 + 32'(i) * 32'h10;
      req_wdata[i*DW +: DW]   = 32'hA000 + 32'(i);
      req_be[i*DW/8 +: DW/8]  = 4'b1111;
    end
    mem_rdata = '0;

    // Reset held with all requesters active.
    rst_n = 1'b0; req_valid = 4'b1111; req_lock = '0; req_we = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    end

    // Single read, then a stray mem_rvalid in IDLE.
    tbl[0] = '{4'b0001, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,   4'b0000, 32'h0};
    tbl[1] = '{4'b0001, 1'b1, 1'b0, 32'h0,        4'b0001, 1'b1, 32'h100, 4'b0000, 32'h0};
    tbl[2] = '{4'b0000, 1'b0, 1'b1, 32'hDEADBEEF, 4'b0000, 1'b0, 32'h0,   4'b0000, 32'h0};
    tbl[3] = '{4'b0000, 1'b0, 1'b1, 32'h12345678, 4'b0000, 1'b0, 32'h0,   4'b0001, 32'hDEADBEEF};
    tbl[4] = '{4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,   4'b0000, 32'h0};
    tbl[5] = '{4'b0000, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,   4'b0000, 32'h0};
    do_reset();
    for (int r = 0; r < 6; r++) begin
      req_valid  = tbl[r].rv;
      mem_ready  = tbl[r].mr;
      mem_rvalid = tbl[r].rvl;
      mem_rdata  = tbl[r].rdata;
      #1;
      chk($sformatf("vec%0d_req_ready", r), 64'(req_ready), 64'(tbl[r].e_rr));
      chk($sformatf("vec%0d_mem_valid", r), 64'(mem_valid), 64'(tbl[r].e_mv));
      if (tbl[r].e_mv) chk($sformatf("vec%0d_mem_addr", r), 64'(mem_addr), 64'(tbl[r].e_addr));
      chk($sformatf("vec%0d_resp_valid", r), 64'(resp_valid), 64'(tbl[r].e_resp));
      if (tbl[r].e_resp != '0)
        chk($sformatf("vec%0d_resp_rdata", r), 64'(resp_rdata), 64'(tbl[r].e_rdata));
      tick();
    end
    mem_rvalid = 1'b0;

    // Round-robin with all requesters active.
    do_reset();
    for (int t = 0; t < 8; t++)
      do_txn($sformatf("rr%0d", t), 4'b1111, t % 4, 32'h5000 + 32'(t), 4'b0000);
    req_valid = '0;

    // Stalled write from requester 3.
    do_reset();
    req_valid = 4'b1000; req_we = 4'b1000; req_be[12 +: 4] = 4'b0011;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_mem_valid", 64'(mem_valid), 64'd1);
      chk("stall_mem_addr", 64'(mem_addr), 64'h130);
      chk("stall_mem_we", 64'(mem_we), 64'd1);
      chk("stall_mem_be", 64'(mem_be), 64'b0011);
      chk("stall_mem_wdata", 64'(mem_wdata), 64'hA003);
      chk("stall_no_ready", 64'(req_ready), 64'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("stall_ready_pulse", 64'(req_ready), 64'b1000);
    tick();
    mem_ready = 1'b0; req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("wait_mem_valid", 64'(mem_valid), 64'd0);
      chk("wait_req_ready", 64'(req_ready), 64'd0);
      chk("wait_resp_valid", 64'(resp_valid), 64'd0);
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
    tick();
    mem_rvalid = 1'b0;
    chk("stall_resp_valid", 64'(resp_valid), 64'b1000);
    chk("stall_resp_rdata", 64'(resp_rdata), 64'hCAFE0001);
    tick();
    chk("stall_resp_once", 64'(resp_valid), 64'd0);
    req_we = '0; req_be[12 +: 4] = 4'b1111;

    // Pointer at 3, then wrap and skip over idle requesters.
    do_reset();
    do_txn("ptr_set", 4'b0100, 2, 32'h77, 4'b0000);
    do_txn("wrap0", 4'b0101, 0, 32'h88, 4'b0000);
    do_txn("skip2", 4'b0101, 2, 32'h99, 4'b0000);
    req_valid = '0;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("idle_rvalid_ignored", 64'(resp_valid), 64'd0);

    // Reset while waiting for the response; late mem_rvalid must be dropped.
    do_reset();
    req_valid = 4'b0010; mem_ready = 1'b1;
    tick();
    chk("midwait_ready", 64'(req_ready), 64'b0010);
    tick();
    mem_ready = 1'b0; req_valid = '0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rvalid_resp", 64'(resp_valid), 64'd0);
    chk("late_rvalid_mv", 64'(mem_valid), 64'd0);
    tick();
    chk("late_rvalid_resp2", 64'(resp_valid), 64'd0);

`ifdef ARB_LOCK_EN
    do_reset();
    req_lock = 4'b0010;
    do_txn("lk_g0", 4'b0011, 0, 32'h1, 4'b0010);
    do_txn("lk_g1a", 4'b0011, 1, 32'h2, 4'b0010);
    do_txn("lk_g1b", 4'b0011, 1, 32'h3, 4'b0010);
    do_txn("lk_g1c", 4'b0011, 1, 32'h4, 4'b0000);
    do_txn("lk_rel0", 4'b0011, 0, 32'h5, 4'b0000);
    req_valid = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
